// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the bit-serial adder.
// Rev 1.0
`default_nettype none

package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done operand and result bundle; sub exists only with SERIAL_ADDER_SUB_EN.
// Rev 1.0
`default_nettype none

interface serial_adder_if #(
  parameter int WIDTH = serial_adder_pkg::DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, sub, input sum, cout, busy, done);
  modport slave  (input start, a, b, sub, output sum, cout, busy, done);
`else
  modport master (output start, a, b, input sum, cout, busy, done);
  modport slave  (input start, a, b, output sum, cout, busy, done);
`endif
endinterface

`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational 1-bit full adder, the only arithmetic in the serial adder.
// Rev 1.0
`default_nettype none

module fa_cell (
  input  wire logic a,
  input  wire logic b,
  input  wire logic cin,
  output logic      s,
  output logic      co
);
  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));
endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one bit per clock LSB first, start/busy/done handshake.
// Optional subtract mode under SERIAL_ADDER_SUB_EN. Rev 1.0
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  serial_adder_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s, fa_co;
  logic             sub_bit;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_bit = bus.sub;
`else
  assign sub_bit = 1'b0;
`endif

  fa_cell u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1: invert B on load and seed the carry.
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{sub_bit}};
          carry_d = sub_bit;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_co;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = (state_q == ST_DONE);

endmodule

`default_nettype wire
